mem_access_stage: RTL

MEM stage of the mipslite pipeline, directly downstream of the EX/MEM register.
- Consumes EX/MEM outputs.
- Runs a request/acknowledge transaction to data memory for loads and stores.
- Stalls the upstream pipeline while the access is outstanding.
- Registers results into MEM/WB for writeback.
- Non-memory instructions pass through in one cycle.

---
 rtl/mem_access_stage_pkg.sv | 6 +
 rtl/mem_access_stage_reg_mem_wb.sv | 50 +++++
 rtl/mem_access_stage.sv | 124 ++++++++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: datapath width, MEM FSM states and default timeout for the MEM stage.
package mem_access_stage_pkg;
  localparam int DATA_W = 32;
  localparam int MEM_TIMEOUT = 255;
  typedef enum logic {MEM_ST_IDLE = 1'b0, MEM_ST_WAIT = 1'b1} mem_st_e;
endpackage

// File: rtl/mem_access_stage_reg_mem_wb.sv
// reg_mem_wb: MEM/WB pipeline register with load enable, bubble insert and separately enabled load data.
module reg_mem_wb #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         bubble_i,
  input  logic         valid_i,
  input  logic         regwrite_i,
  input  logic         wrmux_i,
  input  logic [W-1:0] alu_i,
  input  logic [4:0]   rd_i,
  input  logic         rdata_en_i,
  input  logic [W-1:0] rdata_i,
  output logic         valid_o,
  output logic         regwrite_o,
  output logic         wrmux_o,
  output logic [W-1:0] alu_o,
  output logic [4:0]   rd_o,
  output logic [W-1:0] rdata_o
);
  logic valid_q, regwrite_q, wrmux_q;
  logic [W-1:0] alu_q, rdata_q;
  logic [4:0] rd_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      wrmux_q    <= 1'b0;
      alu_q      <= '0;
      rd_q       <= '0;
      rdata_q    <= '0;
    end else if (en_i) begin
      valid_q    <= valid_i & !bubble_i;
      regwrite_q <= regwrite_i & !bubble_i;
      if (!bubble_i) begin
        wrmux_q <= wrmux_i;
        alu_q   <= alu_i;
        rd_q    <= rd_i;
      end
      if (rdata_en_i) rdata_q <= rdata_i;
    end
  assign valid_o    = valid_q;
  assign regwrite_o = regwrite_q;
  assign wrmux_o    = wrmux_q;
  assign alu_o      = alu_q;
  assign rd_o       = rd_q;
  assign rdata_o    = rdata_q;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: mipslite MEM stage running a req/ack data-memory transaction and feeding MEM/WB.
// Optional MEM_TIMEOUT_EN aborts a WAIT that sees no ack within TIMEOUT_CYCLES.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int LENGTH = DATA_W
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = MEM_TIMEOUT
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic              Memwrite_in,
  input  logic              RegWrite_in,
  input  logic              Write_reg_mux_in,
  input  logic [LENGTH-1:0] ALU_out_in,
  input  logic [LENGTH-1:0] Write_memory_Data_in,
  input  logic [4:0]        Write_Reg_Address_in,
  output logic              stall_out,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [LENGTH-1:0] dmem_addr,
  output logic [LENGTH-1:0] dmem_wdata,
  input  logic [LENGTH-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic              valid_out,
  output logic              RegWrite_out,
  output logic              Write_reg_mux_out,
  output logic [LENGTH-1:0] ALU_out_out,
  output logic [LENGTH-1:0] Read_memory_Data_out,
  output logic [4:0]        Write_Reg_Address_out,
  output logic              misalign_err,
  output logic              timeout_err
);
  mem_st_e state_q, state_d;
  logic req_q, we_q, rw_q, mux_q, mis_q, tmo_q;
  logic [LENGTH-1:0] addr_q, wdata_q;
  logic [4:0] rd_q;
  logic mem_op, misaligned, idle_st, wait_st, start, done, tmo_hit;
  logic wb_bubble, wb_rw, wb_mux, wb_rdata_en;
  logic [LENGTH-1:0] wb_alu;
  logic [4:0] wb_rd;
  assign mem_op     = valid_in & (Memwrite_in | (Write_reg_mux_in & RegWrite_in));
  assign misaligned = mem_op & (ALU_out_in[1:0] != 2'b00);
  assign idle_st    = state_q == MEM_ST_IDLE;
  assign wait_st    = state_q == MEM_ST_WAIT;
  assign start      = idle_st & mem_op & !misaligned;
  assign done       = wait_st & dmem_ack;
`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt_q;
  assign tmo_hit = wait_st & !dmem_ack & (cnt_q + 8'd1 == 8'(TIMEOUT_CYCLES));
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else cnt_q <= start ? 8'd0 : (wait_st & !dmem_ack) ? cnt_q + 8'd1 : cnt_q;
`else
  assign tmo_hit = 1'b0;
`endif
  always_comb begin
    state_d = start ? MEM_ST_WAIT : (done | tmo_hit) ? MEM_ST_IDLE : state_q;
  end
  // gated by rst so every output reads 0 while reset is held
  assign stall_out = rst & (start | (wait_st & !dmem_ack & !tmo_hit));
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= MEM_ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rw_q    <= 1'b0;
      mux_q   <= 1'b0;
      rd_q    <= '0;
      mis_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mis_q   <= idle_st & misaligned;
      tmo_q   <= tmo_hit;
      if (start) begin
        req_q   <= 1'b1;
        we_q    <= Memwrite_in;
        addr_q  <= ALU_out_in;
        wdata_q <= Write_memory_Data_in;
        rw_q    <= RegWrite_in;
        mux_q   <= Write_reg_mux_in;
        rd_q    <= Write_Reg_Address_in;
      end else if (done | tmo_hit) begin
        req_q <= 1'b0;
      end
    end
  // a timeout retires the captured op without a register write, like a misaligned op
  assign wb_bubble   = start | (wait_st & !done & !tmo_hit);
  assign wb_rw       = wait_st ? (rw_q & done) : (RegWrite_in & valid_in & !misaligned);
  assign wb_mux      = wait_st ? mux_q : Write_reg_mux_in;
  assign wb_alu      = wait_st ? addr_q : ALU_out_in;
  assign wb_rd       = wait_st ? rd_q : Write_Reg_Address_in;
  assign wb_rdata_en = done & !we_q;
  reg_mem_wb #(.W(LENGTH)) u_mem_wb (
    .clk       (clk),
    .rst       (rst),
    .en_i      (1'b1),
    .bubble_i  (wb_bubble),
    .valid_i   (wait_st | valid_in),
    .regwrite_i(wb_rw),
    .wrmux_i   (wb_mux),
    .alu_i     (wb_alu),
    .rd_i      (wb_rd),
    .rdata_en_i(wb_rdata_en),
    .rdata_i   (dmem_rdata),
    .valid_o   (valid_out),
    .regwrite_o(RegWrite_out),
    .wrmux_o   (Write_reg_mux_out),
    .alu_o     (ALU_out_out),
    .rd_o      (Write_Reg_Address_out),
    .rdata_o   (Read_memory_Data_out)
  );
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign misalign_err = mis_q;
  assign timeout_err  = tmo_q;
endmodule
